gate_bus_rr_sched: RTL

- Round-robin scheduler that shares one registered bitwise gate-bus datapath among N_REQ requesters.
- Each requester presents an opcode (AND/NAND/OR/NOR/XOR/XNOR/INV/BUF) and two WIDTH-bit operands over a valid/ready handshake.
- The block grants one request per cycle, pushes it through a PIPE_LAT-stage pipeline, and returns the result tagged with the requester ID over a valid/ready result port.
- It sits between the DSP control logic and the shared logic resource, replacing per-client gate instances.

---
 rtl/gate_bus_rr_sched_pkg.sv | 38 +++
 rtl/gate_bus_rr_arb.sv | 38 +++
 rtl/gate_bus_rr_sched.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/gate_bus_rr_sched_pkg.sv
// Shared definitions for the round-robin gate-bus scheduler.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
// Contents: 3-bit opcode constants GB_AND..GB_BUF and gb_eval(), the bitwise
// evaluator. gb_eval works on GB_MAX_W bits; callers zero-extend narrower
// operands and size-cast the result back down to their own width.
package gate_bus_rr_sched_pkg;

  localparam int GB_MAX_W = 64;

  localparam logic [2:0] GB_AND  = 3'd0;
  localparam logic [2:0] GB_NAND = 3'd1;
  localparam logic [2:0] GB_OR   = 3'd2;
  localparam logic [2:0] GB_NOR  = 3'd3;
  localparam logic [2:0] GB_XOR  = 3'd4;
  localparam logic [2:0] GB_XNOR = 3'd5;
  localparam logic [2:0] GB_INV  = 3'd6;
  localparam logic [2:0] GB_BUF  = 3'd7;

  // Plain Verilog operators are used so that X on an operand propagates
  // naturally. IB is ignored for INV and BUF.
  function automatic logic [GB_MAX_W-1:0] gb_eval(input logic [2:0]          op,
                                                  input logic [GB_MAX_W-1:0] ia,
                                                  input logic [GB_MAX_W-1:0] ib);
    case (op)
      GB_AND:  gb_eval = ia & ib;
      GB_NAND: gb_eval = ~(ia & ib);
      GB_OR:   gb_eval = ia | ib;
      GB_NOR:  gb_eval = ~(ia | ib);
      GB_XOR:  gb_eval = ia ^ ib;
      GB_XNOR: gb_eval = ~(ia ^ ib);
      GB_INV:  gb_eval = ~ia;
      GB_BUF:  gb_eval = ia;
      default: gb_eval = '0;
    endcase
  endfunction

endpackage

// File: rtl/gate_bus_rr_arb.sv
// Rotating-priority arbiter: grants the first valid requester at or after i_ptr.
// Latency: purely combinational.
// Backpressure: i_en low forces the grant to zero.
// Ports: i_vld  request bits, one per requester
//        i_ptr  index where the priority search starts
//        i_en   grant enable
//        o_gnt  one-hot grant (all zero when nothing is granted)
//        o_idx  binary index of the granted requester (0 when none)
module gate_bus_rr_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_vld,
  input  logic [ID_W-1:0]  i_ptr,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_idx
);

  always_comb begin
    logic w_found;
    int   w_j;
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = 0;
    // Walk the requesters starting at i_ptr and wrapping modulo N_REQ.
    for (int k = 0; k < N_REQ; k++) begin
      w_j = (int'(i_ptr) + k) % N_REQ;
      if (i_en && !w_found && i_vld[w_j]) begin
        o_gnt[w_j] = 1'b1;
        o_idx      = ID_W'(w_j);
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gate_bus_rr_sched.sv
// Round-robin scheduler that shares one registered bitwise gate-bus datapath.
// Latency: PIPE_LAT cycles from accept to RES_VALID; one accept per cycle.
// Backpressure: RES_READY low freezes every stage and drops REQ_READY to zero.
// Ports: CLK/ACLR_N    clock and asynchronous active-low reset
//        FLUSH         synchronous drop of in-flight work and RR pointer reset
//        REQ_*         per-requester valid/ready, opcode and operands (packed)
//        RES_*         result valid/ready, data and owning requester ID
//        BUSY          any pipeline stage holds a valid entry
module gate_bus_rr_sched #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 16,
  parameter int PIPE_LAT = 2,
  parameter int ID_W     = 2
) (
  input  logic                   CLK,
  input  logic                   ACLR_N,
  input  logic                   FLUSH,
  input  logic [N_REQ-1:0]       REQ_VALID,
  output logic [N_REQ-1:0]       REQ_READY,
  input  logic [3*N_REQ-1:0]     REQ_OP,
  input  logic [WIDTH*N_REQ-1:0] REQ_IA,
  input  logic [WIDTH*N_REQ-1:0] REQ_IB,
  output logic                   RES_VALID,
  input  logic                   RES_READY,
  output logic [WIDTH-1:0]       RES_DATA,
  output logic [ID_W-1:0]        RES_ID,
  output logic                   BUSY
);

  import gate_bus_rr_sched_pkg::*;

  logic                w_adv;
  logic                w_en;
  logic                w_acc;
  logic [N_REQ-1:0]    w_gnt;
  logic [ID_W-1:0]     w_idx;
  logic [ID_W-1:0]     w_ptr_nxt;
  logic [ID_W-1:0]     r_ptr;
  logic [PIPE_LAT-1:0] r_vld;

  logic [2:0]          w_op;
  logic [WIDTH-1:0]    w_ia;
  logic [WIDTH-1:0]    w_ib;
  logic [2:0]          r_op0;
  logic [WIDTH-1:0]    r_ia0;
  logic [WIDTH-1:0]    r_ib0;
  logic [ID_W-1:0]     r_id0;
  logic [WIDTH-1:0]    w_eval;
  logic [WIDTH-1:0]    w_res_dat;
  logic [ID_W-1:0]     w_res_id;

  // The whole pipeline moves as one unit: bubbles are never collapsed.
  assign RES_VALID = r_vld[PIPE_LAT-1];
  assign w_adv     = !RES_VALID | RES_READY;
  assign w_en      = w_adv & !FLUSH;
  assign REQ_READY = w_gnt;
  assign w_acc     = |w_gnt;
  assign BUSY      = |r_vld;

  gate_bus_rr_arb #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .i_vld (REQ_VALID),
    .i_ptr (r_ptr),
    .i_en  (w_en),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign w_ptr_nxt = (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + ID_W'(1);

  // Operand mux driven by the one-hot grant.
  always_comb begin
    w_op = '0;
    w_ia = '0;
    w_ib = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        w_op = REQ_OP[3*i +: 3];
        w_ia = REQ_IA[WIDTH*i +: WIDTH];
        w_ib = REQ_IB[WIDTH*i +: WIDTH];
      end
    end
  end

  // Stage 0 (raw request), valid chain and RR pointer.
  always_ff @(posedge CLK or negedge ACLR_N) begin
    if (!ACLR_N) begin
      r_ptr <= '0;
      r_vld <= '0;
      r_op0 <= '0;
      r_ia0 <= '0;
      r_ib0 <= '0;
      r_id0 <= '0;
    end else begin
      if (FLUSH) begin
        r_vld <= '0;
        r_ptr <= '0;
      end else begin
        if (w_acc) begin
          r_ptr <= w_ptr_nxt;
        end
        if (w_adv) begin
          r_vld[0] <= w_acc;
          for (int k = 1; k < PIPE_LAT; k++) begin
            r_vld[k] <= r_vld[k-1];
          end
        end
      end
      // An accept already implies adv and no flush.
      if (w_acc) begin
        r_op0 <= w_op;
        r_ia0 <= w_ia;
        r_ib0 <= w_ib;
        r_id0 <= w_idx;
      end
    end
  end

  assign w_eval = WIDTH'(gb_eval(r_op0, GB_MAX_W'(r_ia0), GB_MAX_W'(r_ib0)));

  // Evaluation sits between stage 0 and stage 1; later stages only delay.
  // With a single stage the result is evaluated straight off stage 0.
  if (PIPE_LAT == 1) begin : g_lat1
    assign w_res_dat = w_eval;
    assign w_res_id  = r_id0;
  end else begin : g_latn
    logic [WIDTH-1:0] r_dat [PIPE_LAT-1];
    logic [ID_W-1:0]  r_rid [PIPE_LAT-1];

    // Data registers are not cleared by FLUSH; only the valid bits are.
    always_ff @(posedge CLK or negedge ACLR_N) begin
      if (!ACLR_N) begin
        for (int k = 0; k < PIPE_LAT - 1; k++) begin
          r_dat[k] <= '0;
          r_rid[k] <= '0;
        end
      end else if (w_en) begin
        r_dat[0] <= w_eval;
        r_rid[0] <= r_id0;
        for (int k = 1; k < PIPE_LAT - 1; k++) begin
          r_dat[k] <= r_dat[k-1];
          r_rid[k] <= r_rid[k-1];
        end
      end
    end

    assign w_res_dat = r_dat[PIPE_LAT-2];
    assign w_res_id  = r_rid[PIPE_LAT-2];
  end

  assign RES_DATA = w_res_dat;
  assign RES_ID   = w_res_id;

endmodule
